ttt_game_ctrl: RTL and testbench
================================

// Module: ttt_game_ctrl
// PURPOSE
//  Sequences a 3x3 board of tile cells for one tic-tac-toe game. Accepts move requests,
//  rejects illegal ones and pulses the matching tile select with the current turn.
//  After each placement it checks for a win or draw, then alternates turns.
//  Sits between the input decoder (buttons/UART) and the nine tile instances; its
//  outputs also drive the display/LED logic.
// PARAMETERS
//  FIRST_PLAYER     0  side that moves first after reset (0 = X, 1 = O)
//  ALTERNATE_START  1  1: starting side flips on each new_game; 0: always FIRST_PLAYER
// PORTS
//  clk         in   1   system clock
//  reset       in   1   asynchronous, active-high reset
//  new_game    in   1   1-cycle pulse: abort any game and clear the board
//  move_valid  in   1   move request strobe; sampled only while move_ready=1
//  move_idx    in   4   requested tile, 0..8, row-major (0 = top-left)
//  tile_state  in   18  board; bits [2i+1:2i] = tile i (00 empty, 01 X, 10 O)
//  move_ready  out  1   controller is waiting for a move
//  move_err    out  1   1-cycle pulse: last move_valid was illegal
//  tile_sel    out  9   one-hot select to tiles, 1 cycle per accepted move
//  tile_turn   out  1   turn to tiles (0 = X, 1 = O), valid with tile_sel
//  tile_clr    out  1   synchronous clear to all tiles
//  move_cnt    out  4   moves placed this game, 0..9
//  game_over   out  1   game finished (win or draw)
//  winner      out  2   00 none/draw, 01 X, 10 O; valid when game_over=1
//  win_line    out  8   one-hot winning line: rows 0-2, cols 3-5, diag 6, anti-diag 7
// BEHAVIOUR
//  - FSM states: CLEAR, WAIT_MOVE, SELECT, CHECK, DONE. Asynchronous reset forces CLEAR.
//  - Reset values: turn=FIRST_PLAYER, move_cnt=0, game_over=0, winner=00, win_line=0,
//    move_err=0, tile_sel=0. tile_clr=1 (decoded from state CLEAR).
//  - CLEAR: tile_clr=1 for exactly one cycle, then WAIT_MOVE. Clears move_cnt,
//    game_over, winner and win_line. turn loads the starting side.
//  - WAIT_MOVE: move_ready=1. On move_valid:
//    - Legal (move_idx<=8 and tile empty): go to SELECT.
//    - Illegal: move_err=1 on the next cycle; stay in WAIT_MOVE; no tile_sel.
//  - SELECT (1 cycle): tile_sel=1<<idx (registered idx), tile_turn=turn; move_cnt+1.
//  - CHECK (1 cycle): tile_state already shows the new mark. Evaluate the 8 lines
//    for the current player:
//    - Any line complete: game_over=1, winner=turn+1, win_line = all matching lines
//      (a fork may set 2 bits); go to DONE.
//    - Else if move_cnt==9: game_over=1, winner=00; go to DONE.
//    - Else: toggle turn; go to WAIT_MOVE.
//  - Latency: move accepted at edge N -> tile_sel high in cycle N+1 -> result in
//    N+2 -> move_ready high again in N+3.
//  - DONE: outputs hold; move_valid is ignored without move_err.
//  - move_valid outside WAIT_MOVE is ignored (no error, no queueing).
//  - new_game in any state goes to CLEAR next cycle and wins over a simultaneous
//    move_valid. With ALTERNATE_START=1 the starting side flips on each new_game
//    (not on reset).
//  - At most one tile_sel bit is ever set, and tile_sel and tile_clr are never high together.
// STRUCTURE
//  - ttt_pkg: tile codes (EMPTY/X/O), FSM state enum, WIN_LINES[8][3] tile-index table.
//  - Sub-module ttt_line_check: combinational; board[17:0] + player code -> hit[7:0].
//  - All outputs are registered or decoded from the state only. No combinational path
//    from move_valid to tile_sel.
// TESTING
//  1. Reset release -> tile_clr=1 one cycle; move_ready=1; turn=0, move_cnt=0, winner=00.
//  2. X plays 0, O 3, X 1, O 4, X 2 -> game_over=1, winner=01, win_line=8'h01,
//     move_cnt=5; tile_sel pulses seen 001,008,002,010,004 (hex).
//  3. Move on occupied tile 4, then move_idx=9 -> two move_err pulses; turn, move_cnt
//     and tile_sel unchanged.
//  4. Draw sequence 0,1,2,4,3,5,7,6,8 -> game_over=1, winner=00, win_line=0, move_cnt=9.
//  5. new_game during SELECT of move 3 -> CLEAR next cycle, then move_cnt=0; with
//     ALTERNATE_START=1, turn=1 in the following WAIT_MOVE.
//  6. Assert reset while in CHECK -> all outputs return to reset values immediately,
//     before the next clk edge.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe controller: tile codes, FSM states
// and the table of the eight winning lines.
package ttt_pkg;

   typedef enum logic [1:0] {
      TILE_EMPTY = 2'b00,
      TILE_X     = 2'b01,
      TILE_O     = 2'b10
   } tile_t;

   typedef enum logic [2:0] {
      ST_CLEAR,
      ST_WAIT_MOVE,
      ST_SELECT,
      ST_CHECK,
      ST_DONE
   } state_t;

   localparam int NUM_TILES = 9;
   localparam int NUM_LINES = 8;

   // Rows 0-2, columns 3-5, main diagonal 6, anti-diagonal 7.
   localparam logic [3:0] WIN_LINES [NUM_LINES][3] = '{
      '{4'd0, 4'd1, 4'd2},
      '{4'd3, 4'd4, 4'd5},
      '{4'd6, 4'd7, 4'd8},
      '{4'd0, 4'd3, 4'd6},
      '{4'd1, 4'd4, 4'd7},
      '{4'd2, 4'd5, 4'd8},
      '{4'd0, 4'd4, 4'd8},
      '{4'd2, 4'd4, 4'd6}
   };

   function automatic logic [1:0] playerCode(input logic turn);
      return turn ? TILE_O : TILE_X;
   endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational line detector: flags every winning line fully owned by the
// given player code.
module ttt_line_check
   import ttt_pkg::*;
(
   input  logic [17:0] i_board,
   input  logic [1:0]  i_player,
   output logic [7:0]  o_hit
);

   always_comb begin
      o_hit = '0;
      for (int l = 0; l < NUM_LINES; l++) begin
         o_hit[l] = (i_board[2*WIN_LINES[l][0] +: 2] == i_player) &&
                    (i_board[2*WIN_LINES[l][1] +: 2] == i_player) &&
                    (i_board[2*WIN_LINES[l][2] +: 2] == i_player);
      end
   end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game sequencer: validates moves, selects tiles, detects
// win/draw and alternates turns.
module ttt_game_ctrl
   import ttt_pkg::*;
#(
   parameter bit FIRST_PLAYER    = 1'b0,
   parameter bit ALTERNATE_START = 1'b1
)(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_new_game,
   input  logic        i_move_valid,
   input  logic [3:0]  i_move_idx,
   input  logic [17:0] i_tile_state,
   output logic        o_move_ready,
   output logic        o_move_err,
   output logic [8:0]  o_tile_sel,
   output logic        o_tile_turn,
   output logic        o_tile_clr,
   output logic [3:0]  o_move_cnt,
   output logic        o_game_over,
   output logic [1:0]  o_winner,
   output logic [7:0]  o_win_line
);

   state_t      r_state;
   state_t      w_next_state;
   logic        r_turn;
   logic        r_start;
   logic [3:0]  r_idx;
   logic [3:0]  r_move_cnt;
   logic        r_game_over;
   logic [1:0]  r_winner;
   logic [7:0]  r_win_line;
   logic        r_move_err;

   logic [17:0] w_shifted;
   logic        w_move_legal;
   logic        w_accept;
   logic        w_reject;
   logic [1:0]  w_player;
   logic [7:0]  w_hit;

   assign w_shifted    = i_tile_state >> {i_move_idx, 1'b0};
   assign w_move_legal = (i_move_idx <= 4'd8) && (w_shifted[1:0] == TILE_EMPTY);
   assign w_player     = playerCode(r_turn);

   ttt_line_check u_line_check (
      .i_board  (i_tile_state),
      .i_player (w_player),
      .o_hit    (w_hit)
   );

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_reject     = 1'b0;
      if (i_new_game) begin
         w_next_state = ST_CLEAR;
      end else begin
         case (r_state)
            ST_CLEAR:     w_next_state = ST_WAIT_MOVE;
            ST_WAIT_MOVE: begin
               if (i_move_valid) begin
                  if (w_move_legal) begin
                     w_accept     = 1'b1;
                     w_next_state = ST_SELECT;
                  end else begin
                     w_reject     = 1'b1;
                  end
               end
            end
            ST_SELECT:    w_next_state = ST_CHECK;
            ST_CHECK:     w_next_state = ((|w_hit) || (r_move_cnt == 4'd9)) ? ST_DONE : ST_WAIT_MOVE;
            ST_DONE:      w_next_state = ST_DONE;
            default:      w_next_state = ST_CLEAR;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= ST_CLEAR;
      else         r_state <= w_next_state;
   end

   // The starting side flips on new_game only; reset restores FIRST_PLAYER.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_turn      <= FIRST_PLAYER;
         r_start     <= FIRST_PLAYER;
         r_idx       <= '0;
         r_move_cnt  <= '0;
         r_game_over <= 1'b0;
         r_winner    <= 2'b00;
         r_win_line  <= '0;
         r_move_err  <= 1'b0;
      end else begin
         r_move_err <= w_reject;
         if (ALTERNATE_START && i_new_game) r_start <= ~r_start;
         if (w_accept) r_idx <= i_move_idx;
         case (r_state)
            ST_CLEAR: begin
               r_turn      <= r_start;
               r_move_cnt  <= '0;
               r_game_over <= 1'b0;
               r_winner    <= 2'b00;
               r_win_line  <= '0;
            end
            ST_SELECT: r_move_cnt <= r_move_cnt + 4'd1;
            ST_CHECK: begin
               if (!i_new_game) begin
                  if (|w_hit) begin
                     r_game_over <= 1'b1;
                     r_winner    <= w_player;
                     r_win_line  <= w_hit;
                  end else if (r_move_cnt == 4'd9) begin
                     r_game_over <= 1'b1;
                  end else begin
                     r_turn      <= ~r_turn;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign o_move_ready = (r_state == ST_WAIT_MOVE);
   assign o_tile_clr   = (r_state == ST_CLEAR);
   assign o_tile_sel   = (r_state == ST_SELECT) ? (9'd1 << r_idx) : 9'd0;
   assign o_tile_turn  = r_turn;
   assign o_move_cnt   = r_move_cnt;
   assign o_game_over  = r_game_over;
   assign o_winner     = r_winner;
   assign o_win_line   = r_win_line;
   assign o_move_err   = r_move_err;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Self-checking bench for ttt_game_ctrl: directed game scenarios followed by
// random play, compared against a board-level reference model.
module tb_ttt_game_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        newGame;
   logic        moveValid;
   logic [3:0]  moveIdx;
   logic [17:0] tileState = '0;
   logic        moveReady, moveErr, tileTurn, tileClr, gameOver;
   logic [8:0]  tileSel;
   logic [3:0]  moveCnt;
   logic [1:0]  winner;
   logic [7:0]  winLine;

   int testCount = 0;
   int failCount = 0;

   int refBoard [9];
   int refPlayer, refStart, refCount, refWinner, refLine;
   bit refOver;

   always #5 clk = ~clk;

   ttt_game_ctrl #(.FIRST_PLAYER(1'b0), .ALTERNATE_START(1'b1)) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_new_game   (newGame),
      .i_move_valid (moveValid),
      .i_move_idx   (moveIdx),
      .i_tile_state (tileState),
      .o_move_ready (moveReady),
      .o_move_err   (moveErr),
      .o_tile_sel   (tileSel),
      .o_tile_turn  (tileTurn),
      .o_tile_clr   (tileClr),
      .o_move_cnt   (moveCnt),
      .o_game_over  (gameOver),
      .o_winner     (winner),
      .o_win_line   (winLine)
   );

   // Stand-in for the nine tile instances driven by the controller.
   always @(posedge clk) begin
      if (tileClr) tileState <= '0;
      else
         for (int i = 0; i < 9; i++)
            if (tileSel[i]) tileState[2*i +: 2] <= tileTurn ? 2'b10 : 2'b01;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int lineMask(input int p);
      int mark = p + 1;
      int m = 0;
      for (int r = 0; r < 3; r++)
         if (refBoard[3*r] == mark && refBoard[3*r+1] == mark && refBoard[3*r+2] == mark) m |= 1 << r;
      for (int c = 0; c < 3; c++)
         if (refBoard[c] == mark && refBoard[c+3] == mark && refBoard[c+6] == mark) m |= 1 << (3 + c);
      if (refBoard[0] == mark && refBoard[4] == mark && refBoard[8] == mark) m |= 1 << 6;
      if (refBoard[2] == mark && refBoard[4] == mark && refBoard[6] == mark) m |= 1 << 7;
      return m;
   endfunction

   task automatic clearModel();
      for (int i = 0; i < 9; i++) refBoard[i] = 0;
      refPlayer = refStart;
      refCount  = 0;
      refOver   = 0;
      refWinner = 0;
      refLine   = 0;
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, ".ready"}, moveReady, 1);
      checkOutput({tag, ".cnt"},   moveCnt,   refCount);
      checkOutput({tag, ".over"},  gameOver,  0);
      checkOutput({tag, ".turn"},  tileTurn,  refPlayer);
      checkOutput({tag, ".sel"},   tileSel,   0);
      checkOutput({tag, ".clr"},   tileClr,   0);
      checkOutput({tag, ".err"},   moveErr,   0);
   endtask

   task automatic checkDone(input string tag);
      checkOutput({tag, ".ready"},  moveReady, 0);
      checkOutput({tag, ".over"},   gameOver,  1);
      checkOutput({tag, ".winner"}, winner,    refWinner);
      checkOutput({tag, ".line"},   winLine,   refLine);
      checkOutput({tag, ".cnt"},    moveCnt,   refCount);
      checkOutput({tag, ".sel"},    tileSel,   0);
   endtask

   task automatic doReset();
      reset = 1'b1; newGame = 1'b0; moveValid = 1'b0;
      #1;
      checkOutput("rst.clr",    tileClr,   1);
      checkOutput("rst.ready",  moveReady, 0);
      checkOutput("rst.cnt",    moveCnt,   0);
      checkOutput("rst.over",   gameOver,  0);
      checkOutput("rst.winner", winner,    0);
      checkOutput("rst.line",   winLine,   0);
      checkOutput("rst.err",    moveErr,   0);
      checkOutput("rst.sel",    tileSel,   0);
      checkOutput("rst.turn",   tileTurn,  0);
      tick();
      reset = 1'b0;
      refStart = 0;
      clearModel();
      #1;
      checkOutput("rel.clr", tileClr, 1);
      tick();
      checkIdle("afterReset");
   endtask

   // One move request from WAIT_MOVE, followed through to the next stable state.
   task automatic applyStimulus(input int idx);
      bit legal;
      int m;
      legal = (idx <= 8) && (refBoard[idx] == 0);
      moveValid = 1'b1; moveIdx = 4'(idx);
      tick();
      moveValid = 1'b0;
      if (!legal) begin
         checkOutput("ill.err",   moveErr,   1);
         checkOutput("ill.sel",   tileSel,   0);
         checkOutput("ill.ready", moveReady, 1);
         checkOutput("ill.cnt",   moveCnt,   refCount);
         tick();
         checkOutput("ill.pulse", moveErr,   0);
         checkOutput("ill.turn",  tileTurn,  refPlayer);
      end else begin
         checkOutput("sel.sel",   tileSel,   1 << idx);
         checkOutput("sel.turn",  tileTurn,  refPlayer);
         checkOutput("sel.err",   moveErr,   0);
         checkOutput("sel.ready", moveReady, 0);
         refBoard[idx] = refPlayer + 1;
         refCount++;
         tick();
         checkOutput("chk.cnt", moveCnt, refCount);
         checkOutput("chk.sel", tileSel, 0);
         m = lineMask(refPlayer);
         if (m != 0) begin
            refOver = 1; refWinner = refPlayer + 1; refLine = m;
         end else if (refCount == 9) begin
            refOver = 1;
         end else begin
            refPlayer ^= 1;
         end
         tick();
         if (refOver) checkDone("res");
         else         checkIdle("res");
      end
   endtask

   task automatic applyNewGame(input bit withMove);
      newGame = 1'b1;
      if (withMove) begin
         moveValid = 1'b1;
         moveIdx   = 4'($urandom_range(0, 15));
      end
      tick();
      newGame = 1'b0; moveValid = 1'b0;
      checkOutput("ng.clr",   tileClr,   1);
      checkOutput("ng.sel",   tileSel,   0);
      checkOutput("ng.err",   moveErr,   0);
      checkOutput("ng.ready", moveReady, 0);
      refStart ^= 1;
      clearModel();
      tick();
      checkIdle("ng");
   endtask

   task automatic checkDoneIgnore();
      moveValid = 1'b1; moveIdx = 4'($urandom_range(0, 15));
      tick();
      moveValid = 1'b0;
      checkOutput("done.err", moveErr, 0);
      checkDone("done");
   endtask

   int seq2 [5] = '{0, 3, 1, 4, 2};
   int seq4 [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

   initial begin
      int empties [$];
      int r;
      reset = 1'b0; newGame = 1'b0; moveValid = 1'b0; moveIdx = '0;
      #2;
      doReset();

      foreach (seq2[i]) applyStimulus(seq2[i]);
      checkOutput("t2.winner", winner,  2'b01);
      checkOutput("t2.line",   winLine, 8'h01);
      checkOutput("t2.cnt",    moveCnt, 4'd5);
      checkDoneIgnore();

      applyNewGame(1'b0);
      applyStimulus(4);
      applyStimulus(4);
      applyStimulus(9);
      checkOutput("t3.cnt", moveCnt, 4'd1);

      applyNewGame(1'b0);
      foreach (seq4[i]) applyStimulus(seq4[i]);
      checkOutput("t4.winner", winner,   2'b00);
      checkOutput("t4.line",   winLine,  8'h00);
      checkOutput("t4.cnt",    moveCnt,  4'd9);
      checkOutput("t4.over",   gameOver, 1);

      applyNewGame(1'b0);
      moveValid = 1'b1; moveIdx = 4'd4;
      tick();
      moveValid = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      checkOutput("t6.clr",   tileClr,   1);
      checkOutput("t6.cnt",   moveCnt,   0);
      checkOutput("t6.turn",  tileTurn,  0);
      checkOutput("t6.ready", moveReady, 0);
      checkOutput("t6.over",  gameOver,  0);
      doReset();

      applyStimulus(0);
      applyStimulus(1);
      moveValid = 1'b1; moveIdx = 4'd2;
      tick();
      moveValid = 1'b0;
      checkOutput("t5.sel", tileSel, 9'h004);
      applyNewGame(1'b0);
      checkOutput("t5.turn", tileTurn, 1);
      checkOutput("t5.cnt",  moveCnt,  0);

      for (int step = 0; step < 400; step++) begin
         if (refOver) begin
            if ($urandom_range(0, 1) == 1) checkDoneIgnore();
            applyNewGame(1'($urandom_range(0, 1)));
         end else begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
               applyNewGame(1'($urandom_range(0, 1)));
            end else if (r < 16) begin
               empties.delete();
               for (int i = 0; i < 9; i++) if (refBoard[i] == 0) empties.push_back(i);
               applyStimulus(empties[$urandom_range(0, empties.size() - 1)]);
            end else begin
               applyStimulus($urandom_range(0, 15));
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
